register_bank: RTL

// - Register file directly upstream of the ALU; rd_data1/rd_data2 drive its entrada1/entrada2.
// - Two registered read ports, one write port, and write-to-read bypass.
// - Read latency is 1 cycle, so operands line up with the ALU's posedge-registered result.
// - Register 0 is hardwired to zero.

---
 rtl/register_bank.sv | 97 +++++++++
 1 files changed

// File: rtl/register_bank.sv
// Two-read/one-write register file feeding the ALU; reads registered (1 cycle), write-first bypass, r0 reads zero.
// Optional busy scoreboard with advisory hazard output under REG_BANK_SCOREBOARD_EN; rd_en=0 holds both read outputs.
module register_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr1,
   input  logic [ADDR_WIDTH-1:0] rd_addr2,
   output logic [DATA_WIDTH-1:0] rd_data1,
   output logic [DATA_WIDTH-1:0] rd_data2,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_dest,
   output logic                  hazard
);

   logic [DATA_WIDTH-1:0] regs [REG_COUNT];
   logic [DATA_WIDTH-1:0] nxt1;
   logic [DATA_WIDTH-1:0] nxt2;
   logic                  wr_ok;

   // Address 0 and addresses beyond REG_COUNT are never stored and always read as zero.
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (a != '0) && (32'(a) < REG_COUNT);
   endfunction

   assign wr_ok = wr_en && addr_ok(wr_addr);

   always_comb begin
      nxt1 = '0;
      nxt2 = '0;
      if (addr_ok(rd_addr1)) begin
         if (wr_ok && (wr_addr == rd_addr1)) nxt1 = wr_data;
         else                                nxt1 = regs[rd_addr1];
      end
      if (addr_ok(rd_addr2)) begin
         if (wr_ok && (wr_addr == rd_addr2)) nxt2 = wr_data;
         else                                nxt2 = regs[rd_addr2];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regs     <= '{default: '0};
         rd_data1 <= '0;
         rd_data2 <= '0;
      end else begin
         if (wr_ok) regs[wr_addr] <= wr_data;
         if (rd_en) begin
            rd_data1 <= nxt1;
            rd_data2 <= nxt2;
         end
      end
   end

`ifdef REG_BANK_SCOREBOARD_EN
   logic [REG_COUNT-1:0] busy;
   logic [REG_COUNT-1:0] busy_nxt;
   logic                 haz1;
   logic                 haz2;

   // Set is applied after clear so a re-issue on the retiring edge keeps the register pending.
   always_comb begin
      busy_nxt = busy;
      if (wr_ok) busy_nxt[wr_addr] = 1'b0;
      if (iss_valid && addr_ok(iss_dest)) busy_nxt[iss_dest] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end

   always_comb begin
      haz1 = 1'b0;
      haz2 = 1'b0;
      if (addr_ok(rd_addr1))
         haz1 = busy[rd_addr1] && !(wr_ok && (wr_addr == rd_addr1));
      if (addr_ok(rd_addr2))
         haz2 = busy[rd_addr2] && !(wr_ok && (wr_addr == rd_addr2));
   end

   assign hazard = rd_en && (haz1 || haz2);
`else
   logic unused_iss;
   assign unused_iss = ^{iss_valid, iss_dest};
   assign hazard     = 1'b0;
`endif

endmodule
